// File: rtl/skeleton_echo_buffer_if.sv
// Frame-buffer bus bundle for skeleton_echo_buffer.
// The master side drives the controls and samples; the slave side is the buffer itself.
interface skeleton_echo_buffer_if #(
  parameter int BITWIDTH_SYS  = 16,
  parameter int BITWIDTH_HEAD = 32,
  parameter int DEPTH         = 16
);
  localparam int AW = $clog2(DEPTH);

  logic                     START_FLAG;
  logic [1:0]               MODE;
  logic                     WR_EN;
  logic [BITWIDTH_SYS-1:0]  DATA_IN;
  logic                     RD_EN;
  logic [BITWIDTH_SYS-1:0]  DATA_OUT;
  logic                     DATA_VALID;
  logic [BITWIDTH_HEAD-7:0] DATA_HEAD;
  logic                     FULL;
  logic                     EMPTY;
  logic [AW:0]              FILL_LEVEL;

  modport master (
    output START_FLAG, MODE, WR_EN, DATA_IN, RD_EN,
    input  DATA_OUT, DATA_VALID, DATA_HEAD,
    input  FULL, EMPTY, FILL_LEVEL
  );

  modport slave (
    input  START_FLAG, MODE, WR_EN, DATA_IN, RD_EN,
    output DATA_OUT, DATA_VALID, DATA_HEAD,
    output FULL, EMPTY, FILL_LEVEL
  );
endinterface

// File: rtl/skeleton_echo_buffer.sv
// Load/drain echo buffer with per-frame payload transform.
// SKELETON_ECHO_BUFFER_DROP_CNT_EN adds the saturating DROP_CNT output.
module skeleton_echo_buffer #(
  parameter int BITWIDTH_IN   = 16,
  parameter int BITWIDTH_SYS  = 16,
  parameter int BITWIDTH_HEAD = 32,
  parameter int DEPTH         = 16
) (
  input  logic CLK_SYS,
  input  logic nRST,
  input  logic EN,
  skeleton_echo_buffer_if.slave bus
`ifdef SKELETON_ECHO_BUFFER_DROP_CNT_EN
  ,
  output logic [7:0] DROP_CNT
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = BITWIDTH_HEAD - 6;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [4:0]  BWI5 = 5'(BITWIDTH_IN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [BITWIDTH_IN-1:0]  mem [DEPTH];
  logic [AW-1:0]           wptr_q, rptr_q;
  logic [AW:0]             cnt_q;
  logic                    ovf_q;
  logic [1:0]              mode_q;
  logic [BITWIDTH_SYS-1:0] dout_q;
  logic                    vld_q;
`ifdef SKELETON_ECHO_BUFFER_DROP_CNT_EN
  logic [7:0]              drop_q;
`endif

  logic clr, do_wr, do_rd, do_drop;
  logic full, empty;
  logic [BITWIDTH_IN-1:0]  pay, raw, xf;
  logic [BITWIDTH_SYS-1:0] ext;
  logic [25:0]             head_raw;
  logic                    unused_din;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign pay   = bus.DATA_IN[BITWIDTH_SYS-1 -: BITWIDTH_IN];
  assign raw   = mem[rptr_q];
  assign unused_din = ^bus.DATA_IN;

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    do_wr   = 1'b0;
    do_rd   = 1'b0;
    do_drop = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.START_FLAG) begin
          state_d = S_LOAD;
          clr     = 1'b1;
        end
      end
      S_LOAD: begin
        if (!bus.START_FLAG) begin
          state_d = S_DRAIN;
        end else if (bus.WR_EN) begin
          do_wr   = !full;
          do_drop = full;
        end
      end
      S_DRAIN: begin
        // A new frame marker aborts the drain and beats any read.
        if (bus.START_FLAG) begin
          state_d = S_LOAD;
          clr     = 1'b1;
        end else if (empty) begin
          state_d = S_IDLE;
        end else begin
          do_rd = bus.RD_EN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    xf = raw;
    unique case (mode_q)
      2'b01:   xf = ~raw;
      2'b10:   xf = raw + BITWIDTH_IN'(1);
      default: xf = raw;
    endcase
    ext = '0;
    ext[BITWIDTH_SYS-1 -: BITWIDTH_IN] = xf;
  end

  always_ff @(posedge CLK_SYS) begin
    if (do_wr && nRST && EN) begin
      mem[wptr_q] <= pay;
    end
  end

  always_ff @(posedge CLK_SYS) begin
    if (!nRST || !EN) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      mode_q  <= 2'b00;
      dout_q  <= '0;
      vld_q   <= 1'b0;
`ifdef SKELETON_ECHO_BUFFER_DROP_CNT_EN
      drop_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      vld_q   <= do_rd;
      if (clr) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
        ovf_q  <= 1'b0;
        mode_q <= bus.MODE;
`ifdef SKELETON_ECHO_BUFFER_DROP_CNT_EN
        drop_q <= '0;
`endif
      end else begin
        if (do_wr) begin
          wptr_q <= wptr_q + AW'(1);
          cnt_q  <= cnt_q + (AW+1)'(1);
        end
        if (do_rd) begin
          rptr_q <= rptr_q + AW'(1);
          cnt_q  <= cnt_q - (AW+1)'(1);
          dout_q <= ext;
        end
        if (do_drop) begin
          ovf_q <= 1'b1;
`ifdef SKELETON_ECHO_BUFFER_DROP_CNT_EN
          if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
`endif
        end
      end
    end
  end

  assign head_raw = {ovf_q, mode_q, 1'b0, 6'd2, 6'd2, BWI5, BWI5};

  assign bus.DATA_OUT   = dout_q;
  assign bus.DATA_VALID = vld_q;
  assign bus.DATA_HEAD  = HW'(head_raw);
  assign bus.FULL       = full;
  assign bus.EMPTY      = empty;
  assign bus.FILL_LEVEL = cnt_q;
`ifdef SKELETON_ECHO_BUFFER_DROP_CNT_EN
  assign DROP_CNT = drop_q;
`endif

endmodule
